// File: rtl/mdu_ctrl_if.sv
// Bundles the E/D/W-stage signals exchanged between the pipeline and the MDU sequencer.
// The pipeline side uses the master modport and the sequencer uses the slave modport.
interface mdu_ctrl_if #(
    parameter int REG_SIZE = 5
);
    logic                startE;
    logic                isDivE;
    logic                flushE;
    logic [REG_SIZE-1:0] destE;
    logic                mduOpD;
    logic [REG_SIZE-1:0] raddr1D;
    logic [REG_SIZE-1:0] raddr2D;
    logic                regWriteW;

    logic                mduStart;
    logic                mduOpDiv;
    logic                busy;
    logic                stallMdu;
    logic                mduWrite;
    logic [REG_SIZE-1:0] mduWriteReg;
    logic                protoErr;

    modport master (
        output startE, isDivE, flushE, destE, mduOpD, raddr1D, raddr2D, regWriteW,
        input  mduStart, mduOpDiv, busy, stallMdu, mduWrite, mduWriteReg, protoErr
    );

    modport slave (
        input  startE, isDivE, flushE, destE, mduOpD, raddr1D, raddr2D, regWriteW,
        output mduStart, mduOpDiv, busy, stallMdu, mduWrite, mduWriteReg, protoErr
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Times one multiply/divide op, stalls D-stage readers of its destination, and writes back
// through the shared register-file port only on cycles the W stage leaves it free.
module mdu_ctrl #(
    parameter int REG_SIZE = 5,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input logic      clk,
    input logic      reset,
    mdu_ctrl_if.slave mdu
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        WAIT_WB = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_SIZE-1:0] pend_q, pend_d;
    logic                div_q, div_d;
    logic                err_q, err_d;

    logic                accept;
    logic                busy;
    logic                wr_en;
    logic                hit1, hit2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            div_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            div_q   <= div_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        div_d   = div_q;
        err_d   = err_q;
        accept  = 1'b0;
        wr_en   = 1'b0;

        // A second op arriving while one is in flight is a hazard-unit bug; flag and drop it.
        if (state_q != IDLE && mdu.startE) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (mdu.startE && !mdu.flushE) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = mdu.isDivE ? DIV_CNT : MUL_CNT;
                    pend_d  = mdu.destE;
                    div_d   = mdu.isDivE;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = WAIT_WB;
                end
            end
            WAIT_WB: begin
                // W owns the port whenever it writes; the result simply waits here.
                if (!mdu.regWriteW) begin
                    wr_en   = (pend_q != '0);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign hit1 = (mdu.raddr1D != '0) && (mdu.raddr1D == pend_q);
    assign hit2 = (mdu.raddr2D != '0) && (mdu.raddr2D == pend_q);

    // Gated by reset so the start pulse cannot escape while the sequencer is held in reset.
    assign mdu.mduStart    = accept & ~reset;
    assign mdu.mduOpDiv    = div_q;
    assign mdu.busy        = busy;
    assign mdu.stallMdu    = busy & (mdu.mduOpD | hit1 | hit2);
    assign mdu.mduWrite    = wr_en;
    assign mdu.mduWriteReg = wr_en ? pend_q : '0;
    assign mdu.protoErr    = err_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl; expected writebacks go into a scoreboard drained by a monitor.
module tb_mdu_ctrl;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int         at;
        logic [4:0] dst;
    } exp_t;
    exp_t sb[$];

    mdu_ctrl_if #(.REG_SIZE(5)) ifc ();

    mdu_ctrl #(
        .REG_SIZE(5),
        .MUL_LAT (3),
        .DIV_LAT (32),
        .CNT_W   (6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mdu  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [4:0] dst);
        exp_t e;
        e.at  = at;
        e.dst = dst;
        sb.push_back(e);
    endtask

    // Monitor: every writeback the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (ifc.mduWrite === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got reg %0d expected none (cycle %0d)", ifc.mduWriteReg, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_reg", 32'(ifc.mduWriteReg), 32'(e.dst));
                chk("wb_cycle", 32'(cyc), 32'(e.at));
                chk("wb_vs_regWriteW", 32'(ifc.regWriteW), 32'd0);
            end
        end
    end

    task automatic clear_inputs();
        ifc.startE    = 1'b0;
        ifc.isDivE    = 1'b0;
        ifc.flushE    = 1'b0;
        ifc.destE     = '0;
        ifc.mduOpD    = 1'b0;
        ifc.raddr1D   = '0;
        ifc.raddr2D   = '0;
        ifc.regWriteW = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_mduStart"}, 32'(ifc.mduStart), 0);
        chk({tag, "_mduOpDiv"}, 32'(ifc.mduOpDiv), 0);
        chk({tag, "_busy"}, 32'(ifc.busy), 0);
        chk({tag, "_stallMdu"}, 32'(ifc.stallMdu), 0);
        chk({tag, "_mduWrite"}, 32'(ifc.mduWrite), 0);
        chk({tag, "_mduWriteReg"}, 32'(ifc.mduWriteReg), 0);
        chk({tag, "_protoErr"}, 32'(ifc.protoErr), 0);
    endtask

    task automatic start(input logic div, input logic [4:0] dst);
        next();
        clear_inputs();
        ifc.startE = 1'b1;
        ifc.isDivE = div;
        ifc.destE  = dst;
    endtask

    initial begin
        int t0;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clear_inputs();
        ifc.startE = 1'b1;
        #3;
        all_zero("reset");
        next();
        reset = 1'b0;
        clear_inputs();

        // Multiply to r5: busy t1..t4, write at t4.
        start(1'b0, 5'd5);
        t0 = cyc;
        push(t0 + 4, 5'd5);
        #3;
        chk("mul_start", 32'(ifc.mduStart), 1);
        chk("mul_busy_t0", 32'(ifc.busy), 0);
        for (int i = 1; i <= 4; i++) begin
            next();
            clear_inputs();
            #3;
            chk("mul_busy", 32'(ifc.busy), 1);
            chk("mul_opdiv", 32'(ifc.mduOpDiv), 0);
        end
        next();
        #3;
        chk("mul_idle", 32'(ifc.busy), 0);

        // Divide to r7: busy 33 cycles, write at t0+33.
        start(1'b1, 5'd7);
        t0 = cyc;
        push(t0 + 33, 5'd7);
        for (int i = 1; i <= 33; i++) begin
            next();
            clear_inputs();
            #3;
            chk("div_busy", 32'(ifc.busy), 1);
            chk("div_opdiv", 32'(ifc.mduOpDiv), 1);
        end
        next();
        #3;
        chk("div_idle", 32'(ifc.busy), 0);

        // Port conflict: W writes t4..t6, MDU write slips to t7.
        start(1'b0, 5'd3);
        t0 = cyc;
        push(t0 + 7, 5'd3);
        for (int i = 1; i <= 7; i++) begin
            next();
            clear_inputs();
            ifc.regWriteW = (i >= 4 && i <= 6);
            #3;
            if (i >= 4) chk("conf_busy", 32'(ifc.busy), 1);
        end
        next();
        clear_inputs();
        #3;
        chk("conf_idle", 32'(ifc.busy), 0);

        // Stall on source match with pendDest=9.
        start(1'b0, 5'd9);
        t0 = cyc;
        push(t0 + 4, 5'd9);
        next(); clear_inputs(); ifc.raddr2D = 5'd9; #3;
        chk("stall_r2", 32'(ifc.stallMdu), 1);
        next(); clear_inputs(); ifc.raddr1D = 5'd9; #3;
        chk("stall_r1", 32'(ifc.stallMdu), 1);
        next(); clear_inputs(); ifc.raddr1D = 5'd4; ifc.raddr2D = 5'd8; #3;
        chk("stall_nomatch", 32'(ifc.stallMdu), 0);
        next(); clear_inputs(); ifc.mduOpD = 1'b1; #3;
        chk("stall_opd_wait", 32'(ifc.stallMdu), 1);
        next(); clear_inputs(); ifc.mduOpD = 1'b1; ifc.raddr1D = 5'd9; #3;
        chk("stall_drop_idle", 32'(ifc.stallMdu), 0);

        // Destination r0: no write, zero addresses do not stall, mduOpD does.
        start(1'b0, 5'd0);
        next(); clear_inputs(); #3;
        chk("dest0_nostall", 32'(ifc.stallMdu), 0);
        next(); clear_inputs(); ifc.mduOpD = 1'b1; #3;
        chk("dest0_opd", 32'(ifc.stallMdu), 1);
        next(); clear_inputs(); #3;
        next(); clear_inputs(); #3;
        chk("dest0_wait", 32'(ifc.busy), 1);
        next(); #3;
        chk("dest0_idle", 32'(ifc.busy), 0);

        // Flushed start is not accepted.
        start(1'b1, 5'd12);
        ifc.flushE = 1'b1;
        #3;
        chk("flush_start", 32'(ifc.mduStart), 0);
        next(); clear_inputs(); #3;
        chk("flush_busy", 32'(ifc.busy), 0);
        chk("flush_noerr", 32'(ifc.protoErr), 0);

        // Start while busy: ignored, sticky error, original op unaffected.
        start(1'b0, 5'd6);
        t0 = cyc;
        push(t0 + 4, 5'd6);
        next(); clear_inputs(); #3;
        next(); clear_inputs(); ifc.startE = 1'b1; ifc.isDivE = 1'b1; ifc.destE = 5'd8; #3;
        chk("err_nostart", 32'(ifc.mduStart), 0);
        next(); clear_inputs(); #3;
        chk("err_flag", 32'(ifc.protoErr), 1);
        chk("err_opdiv", 32'(ifc.mduOpDiv), 0);
        next(); clear_inputs(); #3;
        next(); #3;
        chk("err_idle", 32'(ifc.busy), 0);
        chk("err_sticky", 32'(ifc.protoErr), 1);

        // Asynchronous reset mid-divide clears everything at once.
        start(1'b1, 5'd10);
        next(); clear_inputs(); #3;
        next(); clear_inputs(); ifc.mduOpD = 1'b1; #3;
        chk("rst_pre_stall", 32'(ifc.stallMdu), 1);
        #1;
        reset = 1'b1;
        #1;
        all_zero("rst_async");
        next(); next();
        reset = 1'b0;
        clear_inputs();
        for (int i = 0; i < 36; i++) next();
        #3;
        chk("rst_idle", 32'(ifc.busy), 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
